xor_apuf_ctrl: RTL and testbench

- Parametrised successor to the single-chain arbiter PUF: K parallel N-stage mux-chain arbiter PUFs, XOR-combined into one response bit.
- Sequences M repeated evaluations per challenge and majority-votes each chain to suppress metastability noise.
- Challenge comes from an external port or an internal LFSR; a start/valid handshake feeds the enrolment/authentication logic above it.

---
 rtl/apuf_pkg.sv | 43 ++++
 rtl/apuf_chain.sv | 54 +++++
 rtl/xor_apuf_ctrl.sv | 174 +++++++++++++++++
 tb/tb_xor_apuf_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apuf_pkg.sv
// Shared types, LFSR tap constants and parameter checks for the XOR arbiter PUF controller.
package apuf_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_ARM     = 3'd2,
      S_LAUNCH  = 3'd3,
      S_CAPTURE = 3'd4,
      S_DONE    = 3'd5
   } state_e;

   // Tap masks: bit (e-1) set for every x^e term of the feedback polynomial
   localparam logic [63:0] TAPS_N16 = 64'h0000_0000_0000_B400;
   localparam logic [63:0] TAPS_N32 = 64'h0000_0000_8020_0003;
   localparam logic [63:0] TAPS_N64 = 64'hD800_0000_0000_0000;

   function automatic logic [63:0] lfsr_taps(input int unsigned n);
      case (n)
         16:      return TAPS_N16;
         32:      return TAPS_N32;
         default: return TAPS_N64;
      endcase
   endfunction

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit params_ok(input int unsigned n, input int unsigned k,
                                    input int unsigned m, input int unsigned settle);
      return ((n == 16) || (n == 32) || (n == 64)) &&
             (k >= 1) && (k <= 8) &&
             (m >= 1) && (m <= 15) && ((m % 2) == 1) &&
             (settle >= 3);
   endfunction

endpackage

// File: rtl/apuf_chain.sv
// One arbiter PUF chain: crossed/straight mux chain, arbiter flop and 2-FF synchroniser.
module apuf_chain #(
   parameter int unsigned N = 32
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic [N-1:0] chal_i,
   input  logic         launch_i,
   input  logic         clr_i,
   output logic         sync_out_o
);

   logic top_c;
   logic bot_c;
   logic arb_q;
   logic sync1_q;
   logic sync2_q;

   // Each stage passes the pair straight (chal=0) or swaps them (chal=1)
   always_comb begin
      logic t;
      logic b;
      logic t_nxt;
      t = launch_i;
      b = launch_i;
      for (int unsigned i = 0; i < N; i++) begin
         t_nxt = chal_i[i] ? b : t;
         b     = chal_i[i] ? t : b;
         t     = t_nxt;
      end
      top_c = t;
      bot_c = b;
   end

   // Arbiter samples the top path once the bottom edge has arrived
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         arb_q   <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else if (clr_i) begin
         arb_q   <= 1'b0;
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         if (bot_c) arb_q <= top_c;
         sync1_q <= arb_q;
         sync2_q <= sync1_q;
      end
   end

   assign sync_out_o = sync2_q;

endmodule

// File: rtl/xor_apuf_ctrl.sv
// K-chain XOR arbiter PUF controller with M-way majority voting per chain and LFSR challenges.
module xor_apuf_ctrl
   import apuf_pkg::*;
#(
   parameter int unsigned N      = 32,
   parameter int unsigned K      = 4,
   parameter int unsigned M      = 5,
   parameter int unsigned SETTLE = 8,
   parameter logic [63:0] SEED   = 64'h0000_0000_ACE1_2024
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic         chal_src_i,
   input  logic [N-1:0] chal_in_i,
   input  logic         tm_en_i,
   input  logic [K-1:0] tm_bits_i,
   output logic         busy_o,
   output logic         resp_valid_o,
   output logic         resp_o,
   output logic [K-1:0] resp_raw_o,
   output logic         stable_o,
   output logic [N-1:0] chal_out_o
);

   localparam int unsigned CW = clog2(M + 1);
   localparam int unsigned SW = clog2(SETTLE);
   localparam logic [N-1:0] TAPS = N'(lfsr_taps(N));

   if (!params_ok(N, K, M, SETTLE)) begin : g_bad_params
      $error("xor_apuf_ctrl: unsupported N/K/M/SETTLE combination");
   end
   if (SEED[N-1:0] == '0) begin : g_bad_seed
      $error("xor_apuf_ctrl: SEED must be nonzero in its low N bits");
   end

   state_e               state_q,      state_d;
   logic [N-1:0]         chal_q,       chal_d;
   logic [N-1:0]         lfsr_q,       lfsr_d;
   logic [K-1:0][CW-1:0] vote_q,       vote_d;
   logic [CW-1:0]        eval_q,       eval_d;
   logic [SW-1:0]        settle_q,     settle_d;
   logic                 busy_q,       busy_d;
   logic                 resp_valid_q, resp_valid_d;
   logic                 resp_q,       resp_d;
   logic [K-1:0]         resp_raw_q,   resp_raw_d;
   logic                 stable_q,     stable_d;

   logic                 launch_c;
   logic                 clr_c;
   logic [N-1:0]         lfsr_nxt_c;
   logic [K-1:0]         sync_c;
   logic [K-1:0]         raw_c;
   logic [K-1:0][CW-1:0] vote_nxt_c;
   logic [K-1:0]         maj_c;
   logic [K-1:0]         unan_c;

   assign lfsr_nxt_c = {lfsr_q[N-2:0], ^(lfsr_q & TAPS)};

   for (genvar gk = 0; gk < K; gk++) begin : g_chain
      apuf_chain #(.N(N)) u_chain (
         .clk_i      (clk_i),
         .rst_ni     (rst_ni),
         .chal_i     (chal_q),
         .launch_i   (launch_c),
         .clr_i      (clr_c),
         .sync_out_o (sync_c[gk])
      );
   end

   assign raw_c = tm_en_i ? tm_bits_i : sync_c;

   // Vote totals including the bit being captured this cycle
   always_comb begin
      for (int unsigned k = 0; k < K; k++) begin
         vote_nxt_c[k] = vote_q[k] + CW'(raw_c[k]);
         maj_c[k]      = (vote_nxt_c[k] > CW'(M / 2));
         unan_c[k]     = (vote_nxt_c[k] == '0) || (vote_nxt_c[k] == CW'(M));
      end
   end

   always_comb begin
      state_d      = state_q;
      chal_d       = chal_q;
      lfsr_d       = lfsr_q;
      vote_d       = vote_q;
      eval_d       = eval_q;
      settle_d     = settle_q;
      busy_d       = busy_q;
      resp_valid_d = 1'b0;
      resp_d       = resp_q;
      resp_raw_d   = resp_raw_q;
      stable_d     = stable_q;
      launch_c     = 1'b0;
      clr_c        = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = S_LOAD;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            chal_d  = chal_src_i ? lfsr_nxt_c : chal_in_i;
            if (chal_src_i) lfsr_d = lfsr_nxt_c;
            vote_d  = '0;
            eval_d  = '0;
            state_d = S_ARM;
         end
         S_ARM: begin
            clr_c    = 1'b1;
            settle_d = '0;
            state_d  = S_LAUNCH;
         end
         S_LAUNCH: begin
            launch_c = 1'b1;
            settle_d = settle_q + SW'(1);
            if (settle_q == SW'(SETTLE - 1)) state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            vote_d = vote_nxt_c;
            eval_d = eval_q + CW'(1);
            if (eval_q == CW'(M - 1)) begin
               state_d      = S_DONE;
               busy_d       = 1'b0;
               resp_valid_d = 1'b1;
               resp_raw_d   = maj_c;
               resp_d       = ^maj_c;
               stable_d     = &unan_c;
            end else begin
               state_d = S_ARM;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         chal_q       <= '0;
         lfsr_q       <= SEED[N-1:0];
         vote_q       <= '0;
         eval_q       <= '0;
         settle_q     <= '0;
         busy_q       <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_q       <= 1'b0;
         resp_raw_q   <= '0;
         stable_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         chal_q       <= chal_d;
         lfsr_q       <= lfsr_d;
         vote_q       <= vote_d;
         eval_q       <= eval_d;
         settle_q     <= settle_d;
         busy_q       <= busy_d;
         resp_valid_q <= resp_valid_d;
         resp_q       <= resp_d;
         resp_raw_q   <= resp_raw_d;
         stable_q     <= stable_d;
      end
   end

   assign busy_o       = busy_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_o       = resp_q;
   assign resp_raw_o   = resp_raw_q;
   assign stable_o     = stable_q;
   assign chal_out_o   = chal_q;

endmodule

// File: tb/tb_xor_apuf_ctrl.sv
// Scoreboard bench for xor_apuf_ctrl: default instance plus a minimal N=16/K=1/M=1/SETTLE=3 instance.
module tb_xor_apuf_ctrl;

   localparam logic [31:0] SEED32 = 32'hACE1_2024;

   typedef struct {
      logic [3:0]  raw;
      logic        resp;
      logic        stable;
      logic [31:0] chal;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_errors = 0;

   exp_t sb[$];
   exp_t sb2[$];
   logic [31:0] lfsr_m;

   logic        rst_n;
   logic        start, chal_src, tm_en;
   logic [31:0] chal_in;
   logic [3:0]  tm_bits;
   logic        busy, resp_valid, resp, stable;
   logic [3:0]  resp_raw;
   logic [31:0] chal_out;

   logic        start2, chal_src2, tm_en2;
   logic [15:0] chal_in2;
   logic [0:0]  tm2;
   logic        busy2, resp_valid2, resp2, stable2;
   logic [0:0]  resp_raw2;
   logic [15:0] chal_out2;

   xor_apuf_ctrl dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start),
      .chal_src_i   (chal_src),
      .chal_in_i    (chal_in),
      .tm_en_i      (tm_en),
      .tm_bits_i    (tm_bits),
      .busy_o       (busy),
      .resp_valid_o (resp_valid),
      .resp_o       (resp),
      .resp_raw_o   (resp_raw),
      .stable_o     (stable),
      .chal_out_o   (chal_out)
   );

   xor_apuf_ctrl #(.N(16), .K(1), .M(1), .SETTLE(3)) dut2 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .start_i      (start2),
      .chal_src_i   (chal_src2),
      .chal_in_i    (chal_in2),
      .tm_en_i      (tm_en2),
      .tm_bits_i    (tm2),
      .busy_o       (busy2),
      .resp_valid_o (resp_valid2),
      .resp_o       (resp2),
      .resp_raw_o   (resp_raw2),
      .stable_o     (stable2),
      .chal_out_o   (chal_out2)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
   endfunction

   // Response monitors: every resp_valid must match the oldest expectation
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (sb.size() == 0) begin
            check_eq("unexp_valid", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("valid_cyc", 64'(cyc),  64'(e.cyc));
            check_eq("resp_raw",  64'(resp_raw), 64'(e.raw));
            check_eq("resp",      64'(resp),     64'(e.resp));
            check_eq("stable",    64'(stable),   64'(e.stable));
            check_eq("chal_out",  64'(chal_out), 64'(e.chal));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && resp_valid2) begin
         if (sb2.size() == 0) begin
            check_eq("unexp_valid2", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb2.pop_front();
            check_eq("valid_cyc2", 64'(cyc),       64'(e.cyc));
            check_eq("resp_raw2",  64'(resp_raw2), 64'(e.raw[0]));
            check_eq("resp2",      64'(resp2),     64'(e.resp));
            check_eq("stable2",    64'(stable2),   64'(e.stable));
            check_eq("chal_out2",  64'(chal_out2), 64'(e.chal[15:0]));
         end
      end
   end

   // One evaluation; caller is at a negedge with the DUT idle. tm_bits switches ba->bb before capture sw.
   task automatic run_one(input logic src, input logic [31:0] chal, input logic [3:0] ba,
                          input logic [3:0] bb, input int sw, input bit pulses);
      exp_t e;
      int   votes [4];
      logic [3:0] bits;
      for (int k = 0; k < 4; k++) votes[k] = 0;
      for (int c = 0; c < 5; c++) begin
         bits = (c < sw) ? ba : bb;
         for (int k = 0; k < 4; k++) votes[k] += int'(bits[k]);
      end
      e.stable = 1'b1;
      for (int k = 0; k < 4; k++) begin
         e.raw[k] = (votes[k] > 2);
         if (!(votes[k] == 0 || votes[k] == 5)) e.stable = 1'b0;
      end
      e.resp = ^e.raw;
      if (src) lfsr_m = lfsr_step(lfsr_m);
      e.chal = src ? lfsr_m : chal;
      e.cyc  = cyc + 52;
      sb.push_back(e);
      chal_src = src;
      chal_in  = chal;
      tm_bits  = ba;
      start    = 1'b1;
      for (int i = 1; i <= 53; i++) begin
         @(negedge clk);
         start = pulses && (i == 5 || i == 11 || i == 52);
         if (i == 6 + 10 * sw) tm_bits = bb;
         check_eq("busy", 64'(busy), 64'(i >= 1 && i <= 51));
      end
   endtask

   task automatic reset_abort();
      chal_src = 1'b1;
      tm_bits  = 4'b1111;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("rst_busy",     64'(busy),       64'd0);
      check_eq("rst_valid",    64'(resp_valid), 64'd0);
      check_eq("rst_resp",     64'(resp),       64'd0);
      check_eq("rst_resp_raw", 64'(resp_raw),   64'd0);
      check_eq("rst_stable",   64'(stable),     64'd0);
      check_eq("rst_chal_out", 64'(chal_out),   64'd0);
      sb.delete();
      lfsr_m = SEED32;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // start held high across two IDLE visits: one accept per visit
   task automatic handshake();
      exp_t e;
      e.raw    = 4'b0101;
      e.resp   = 1'b0;
      e.stable = 1'b1;
      e.chal   = 32'hDEAD_BEEF;
      e.cyc    = cyc + 52;
      sb.push_back(e);
      e.cyc    = cyc + 105;
      sb.push_back(e);
      chal_src = 1'b0;
      chal_in  = 32'hDEAD_BEEF;
      tm_bits  = 4'b0101;
      start    = 1'b1;
      for (int i = 1; i <= 106; i++) begin
         int p;
         @(negedge clk);
         start = (i < 106);
         p = i % 53;
         check_eq("hs_busy", 64'(busy), 64'(p >= 1 && p <= 51));
      end
   endtask

   task automatic sweep();
      for (int r = 0; r < 4; r++) begin
         exp_t e;
         int   c0;
         c0        = cyc;
         chal_src2 = 1'b0;
         chal_in2  = 16'($urandom);
         tm2       = 1'($urandom);
         start2    = 1'b1;
         for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start2 = 1'b0;
            tm2    = 1'($urandom);
            if (i == 6) begin
               e.raw    = {3'b000, tm2};
               e.resp   = tm2[0];
               e.stable = 1'b1;
               e.chal   = {16'h0, chal_in2};
               e.cyc    = c0 + 7;
               sb2.push_back(e);
            end
            check_eq("busy2", 64'(busy2), 64'(i >= 1 && i <= 6));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      chal_src  = 1'b0;
      chal_in   = '0;
      tm_en     = 1'b1;
      tm_bits   = '0;
      start2    = 1'b0;
      chal_src2 = 1'b0;
      chal_in2  = '0;
      tm_en2    = 1'b1;
      tm2       = '0;
      lfsr_m    = SEED32;
      repeat (3) @(negedge clk);
      check_eq("por_busy",      64'(busy),       64'd0);
      check_eq("por_valid",     64'(resp_valid), 64'd0);
      check_eq("por_resp_raw",  64'(resp_raw),   64'd0);
      check_eq("por_stable",    64'(stable),     64'd0);
      check_eq("por_chal_out",  64'(chal_out),   64'd0);
      check_eq("por_chal_out2", 64'(chal_out2),  64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_one(1'b0, 32'hA5A5_A5A5, 4'b1011, 4'b1011, 5, 1'b1);
      run_one(1'b0, 32'h1234_5678, 4'b0110, 4'b1001, 3, 1'b0);
      reset_abort();
      run_one(1'b1, $urandom, 4'b1110, 4'b1110, 5, 1'b0);
      run_one(1'b1, $urandom, 4'b0001, 4'b1000, 2, 1'b0);
      run_one(1'b1, $urandom, 4'b1111, 4'b0000, 4, 1'b0);
      handshake();
      sweep();

      repeat (60) @(negedge clk);
      check_eq("idle_busy",  64'(busy),       64'd0);
      check_eq("sb_drain",   64'(sb.size()),  64'd0);
      check_eq("sb2_drain",  64'(sb2.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
